// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch-stage defaults and the fetch FSM encoding.
package cpu_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_STEP_DEFAULT  = 32'd4;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {pc, inst} holding slot used when the IF/ID register is stalled
// and a fetched word still has to be kept.
module fetch_skid_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic        flush,
  input  logic [31:0] push_pc,
  input  logic [31:0] push_inst,
  output logic        full,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst
);

  // Flush wins over everything so a redirect never leaves a stale word behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full     <= 1'b0;
      out_pc   <= 32'h0;
      out_inst <= 32'h0;
    end else if (flush) begin
      full <= 1'b0;
    end else if (push) begin
      full     <= 1'b1;
      out_pc   <= push_pc;
      out_inst <= push_inst;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage controller: owns the PC, runs the imem request/ack handshake,
// handles redirects (including while a fetch is in flight) and presents
// fetched words to the IF/ID register through a one-entry skid buffer.
module pc_fetch_ctrl
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_ack,
  input  logic [31:0] inst_rdata,
  output logic [31:0] pc,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst
);

  fetch_state_t state, state_next;
  logic [31:0]  pc_next;
  logic         kill, kill_next;
  logic [31:0]  pend_pc, pend_pc_next;
  logic         accept;
  logic         consume;
  logic         skid_push;
  logic         skid_pop;
  logic         skid_full;
  logic [31:0]  skid_pc;
  logic [31:0]  skid_inst;

  assign inst_req  = (state == REQ);
  assign inst_addr = pc;

  assign consume   = if_valid & ~stall;
  assign skid_push = accept & if_valid & ~consume;
  assign skid_pop  = consume & skid_full;

  // FSM state and PC/kill bookkeeping registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      kill    <= 1'b0;
      pend_pc <= 32'h0;
    end else begin
      state   <= state_next;
      pc      <= pc_next;
      kill    <= kill_next;
      pend_pc <= pend_pc_next;
    end
  end

  // Next-state logic: a redirect during an outstanding request is remembered
  // in kill/pend_pc so the in-flight word is dropped when its ack arrives.
  always_comb begin
    state_next   = state;
    pc_next      = pc;
    kill_next    = kill;
    pend_pc_next = pend_pc;
    accept       = 1'b0;
    case (state)
      IDLE: begin
        if (redirect_valid) begin
          pc_next = redirect_pc;
        end else if (!skid_full) begin
          state_next = REQ;
        end
      end
      REQ: begin
        if (inst_ack) begin
          state_next = IDLE;
          kill_next  = 1'b0;
          if (redirect_valid) begin
            pc_next = redirect_pc;
          end else if (kill) begin
            pc_next = pend_pc;
          end else begin
            pc_next = pc + PC_STEP;
            accept  = 1'b1;
          end
        end else if (redirect_valid) begin
          kill_next    = 1'b1;
          pend_pc_next = redirect_pc;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // IF/ID output register: flush beats stall, then fresh word, then skid refill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_valid <= 1'b0;
      if_pc    <= 32'h0;
      if_inst  <= 32'h0;
    end else if (redirect_valid) begin
      if_valid <= 1'b0;
    end else if (accept && (!if_valid || consume)) begin
      if_valid <= 1'b1;
      if_pc    <= pc;
      if_inst  <= inst_rdata;
    end else if (skid_pop) begin
      if_valid <= 1'b1;
      if_pc    <= skid_pc;
      if_inst  <= skid_inst;
    end else if (consume) begin
      if_valid <= 1'b0;
    end
  end

  fetch_skid_buf u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (skid_push),
    .pop       (skid_pop),
    .flush     (redirect_valid),
    .push_pc   (pc),
    .push_inst (inst_rdata),
    .full      (skid_full),
    .out_pc    (skid_pc),
    .out_inst  (skid_inst)
  );

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: a table of sequential fetches plus
// hand-written redirect, stall, wrap and reset sequences. Every word expected
// at the IF/ID output is queued when its ack is driven and compared when the
// output register hands it downstream.
module tb_pc_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_ack;
  logic [31:0] inst_rdata;
  logic [31:0] pc;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } sb_entry_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          delay;
  } vec_t;

  sb_entry_t sb[$];
  sb_entry_t sb_exp;
  vec_t      vecs[5];
  int        checks;
  int        failures;

  pc_fetch_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_req       (inst_req),
    .inst_addr      (inst_addr),
    .inst_ack       (inst_ack),
    .inst_rdata     (inst_rdata),
    .pc             (pc),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_inst        (if_inst)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitReq(input logic [31:0] exp_addr, input string name);
    int n;
    n = 0;
    while (!inst_req && n < 20) begin
      tick();
      n++;
    end
    if (!inst_req) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s timeout waiting for inst_req, expected addr=%h", name, exp_addr);
    end else begin
      checkOutput(name, inst_addr, exp_addr);
    end
  endtask

  // Ack the outstanding request after 'delay' cycles and queue the word
  // the IF/ID register is expected to present for it.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data, input int delay);
    sb_entry_t e;
    repeat (delay - 1) tick();
    inst_ack   = 1'b1;
    inst_rdata = data;
    e.pc   = addr;
    e.inst = data;
    sb.push_back(e);
    tick();
    inst_ack   = 1'b0;
    inst_rdata = 32'h0;
  endtask

  // Scoreboard side: every word taken downstream must be the next expected one.
  always @(negedge clk) begin
    if (!rst && if_valid && !stall) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_if_valid actual if_pc=%h if_inst=%h expected no word", if_pc, if_inst);
      end else begin
        sb_exp = sb.pop_front();
        checkOutput("if_pc", if_pc, sb_exp.pc);
        checkOutput("if_inst", if_inst, sb_exp.inst);
      end
    end
  end

  initial begin
    checks         = 0;
    failures       = 0;
    rst            = 1'b1;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    inst_ack       = 1'b0;
    inst_rdata     = 32'h0;

    vecs[0] = '{32'h0000_0000, 32'h1111_1111, 1};
    vecs[1] = '{32'h0000_0004, 32'h2222_2222, 1};
    vecs[2] = '{32'h0000_0008, 32'h3333_3333, 1};
    vecs[3] = '{32'h0000_000C, 32'h4444_4444, 3};
    vecs[4] = '{32'h0000_0010, 32'h5555_5555, 2};

    // Reset state.
    #12;
    checkOutput("rst_inst_req", {31'h0, inst_req}, 32'h0);
    checkOutput("rst_pc", pc, 32'h0);
    checkOutput("rst_if_valid", {31'h0, if_valid}, 32'h0);
    checkOutput("rst_if_pc", if_pc, 32'h0);
    checkOutput("rst_if_inst", if_inst, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Sequential fetches with assorted ack latencies.
    for (int i = 0; i < 5; i++) begin
      waitReq(vecs[i].addr, "seq_inst_addr");
      applyStimulus(vecs[i].addr, vecs[i].data, vecs[i].delay);
    end

    // Redirect while 0x14 is outstanding; the late ack must be dropped.
    waitReq(32'h0000_0014, "kill_inst_addr");
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    tick();
    redirect_valid = 1'b0;
    checkOutput("kill_req_held", {31'h0, inst_req}, 32'h1);
    checkOutput("kill_addr_held", inst_addr, 32'h0000_0014);
    tick();
    inst_ack   = 1'b1;
    inst_rdata = 32'hDEAD_DEAD;
    tick();
    inst_ack   = 1'b0;
    inst_rdata = 32'h0;
    checkOutput("kill_if_valid", {31'h0, if_valid}, 32'h0);
    waitReq(32'h0000_0100, "redirect_inst_addr");
    applyStimulus(32'h0000_0100, 32'h0100_0100, 1);

    // Redirect to 0x4 with the ack one cycle later (pending-pc path).
    waitReq(32'h0000_0104, "seq_after_redirect");
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0004;
    tick();
    redirect_valid = 1'b0;
    inst_ack       = 1'b1;
    inst_rdata     = 32'hBADB_AD01;
    tick();
    inst_ack   = 1'b0;
    inst_rdata = 32'h0;

    // Stall with 0x4 presented; 0x8 lands in the skid buffer.
    waitReq(32'h0000_0004, "pend_inst_addr");
    stall = 1'b1;
    applyStimulus(32'h0000_0004, 32'h4444_0000, 1);
    waitReq(32'h0000_0008, "stall_inst_addr");
    applyStimulus(32'h0000_0008, 32'h8888_0000, 1);
    for (int i = 0; i < 3; i++) begin
      checkOutput("skid_no_req", {31'h0, inst_req}, 32'h0);
      checkOutput("stall_if_valid", {31'h0, if_valid}, 32'h1);
      checkOutput("stall_if_pc", if_pc, 32'h0000_0004);
      checkOutput("stall_if_inst", if_inst, 32'h4444_0000);
      tick();
    end
    stall = 1'b0;
    tick();
    checkOutput("skid_drain_valid", {31'h0, if_valid}, 32'h1);
    checkOutput("skid_drain_pc", if_pc, 32'h0000_0008);
    waitReq(32'h0000_000C, "resume_inst_addr");

    // Ack, redirect and stall in one cycle.
    stall          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0040;
    inst_ack       = 1'b1;
    inst_rdata     = 32'hBAD0_BAD0;
    tick();
    stall          = 1'b0;
    redirect_valid = 1'b0;
    inst_ack       = 1'b0;
    inst_rdata     = 32'h0;
    checkOutput("combo_if_valid", {31'h0, if_valid}, 32'h0);
    checkOutput("combo_pc", pc, 32'h0000_0040);
    checkOutput("combo_idle", {31'h0, inst_req}, 32'h0);
    tick();
    checkOutput("combo_skid_empty_req", {31'h0, inst_req}, 32'h1);
    checkOutput("combo_inst_addr", inst_addr, 32'h0000_0040);

    // PC wrap from 0xFFFF_FFFC to 0x0.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    inst_ack       = 1'b1;
    inst_rdata     = 32'hBAD0_0040;
    tick();
    redirect_valid = 1'b0;
    inst_ack       = 1'b0;
    inst_rdata     = 32'h0;
    waitReq(32'hFFFF_FFFC, "wrap_inst_addr");
    applyStimulus(32'hFFFF_FFFC, 32'hCAFE_F00D, 1);
    waitReq(32'h0000_0000, "wrap_next_addr");

    // Asynchronous reset in the middle of a request.
    #3;
    rst = 1'b1;
    #1;
    checkOutput("arst_inst_req", {31'h0, inst_req}, 32'h0);
    checkOutput("arst_pc", pc, 32'h0);
    checkOutput("arst_if_valid", {31'h0, if_valid}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();
    checkOutput("post_rst_req", {31'h0, inst_req}, 32'h1);
    checkOutput("post_rst_addr", inst_addr, 32'h0);
    checkOutput("post_rst_if_valid", {31'h0, if_valid}, 32'h0);
    tick();
    checkOutput("post_rst_if_valid2", {31'h0, if_valid}, 32'h0);
    applyStimulus(32'h0000_0000, 32'h1234_5678, 1);
    tick();
    tick();
    checkOutput("sb_drained", sb.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
Fetch-stage controller that owns the program counter and sequences the instruction-memory request/acknowledge handshake. It replaces the free-running PC incrementer. It holds the PC on downstream stall, applies branch/jump redirects (including ones that arrive while a fetch is outstanding), and presents one valid instruction per accepted fetch to the IF/ID register.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
PC_STEP, 4, sequential PC increment in bytes

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
stall  input  1  IF/ID stall: the if_* outputs must not advance
redirect_valid  input  1  branch/jump resolved taken this cycle
redirect_pc  input  32  redirect target, sampled when redirect_valid=1
inst_req  output  1  instruction-memory request; also the imem chip enable
inst_addr  output  32  fetch address; equals pc
inst_ack  input  1  imem data valid this cycle; completes the request
inst_rdata  input  32  instruction word, valid when inst_ack=1
pc  output  32  current fetch PC
if_valid  output  1  if_pc/if_inst hold a live instruction
if_pc  output  32  PC of the presented instruction
if_inst  output  32  presented instruction word

Behaviour:
- Reset (async, rst=1):
  - pc=RESET_PC; state=IDLE; inst_req=0; if_valid=0; if_pc=0; if_inst=0.
  - Skid buffer is emptied; kill flag=0; pend_pc=0.
  - The imem shares rst, so no response from before reset can arrive afterwards.
- States: IDLE (no request), REQ (request outstanding).
- inst_req=1 exactly when state=REQ. inst_addr=pc, held stable while in REQ.
- IDLE->REQ: next cycle when the skid buffer is empty and redirect_valid=0. A redirect in IDLE loads pc<=redirect_pc and stays in IDLE for that cycle.
- REQ without ack:
  - Request and address are held.
  - redirect_valid=1 sets kill=1 and pend_pc<=redirect_pc. A later redirect overwrites pend_pc (latest wins).
- REQ with ack:
  - If kill=1 or redirect_valid=1: drop inst_rdata. pc<=redirect_pc if redirect_valid, else pend_pc. Clear kill. Go to IDLE.
  - Otherwise accept the word as {pc, inst_rdata}. pc<=pc+PC_STEP, modulo 2^32 (0xFFFF_FFFC wraps to 0x0). Go to IDLE.
  - Throughput is therefore at most one fetch per 2 cycles with a 1-cycle ack. This is intentional for the multi-cycle lab core.
- Output register (if_*) and one-entry skid buffer:
  - Consume condition: if_valid=1 and stall=0.
  - An accepted word goes to if_* if the register is empty or being consumed. Otherwise it goes to the skid buffer.
  - When if_* is consumed and the skid buffer is full, the skid entry moves to if_* next cycle.
  - No new request is issued while the skid buffer is full. The buffer therefore never overflows.
  - With stall=1, if_valid/if_pc/if_inst are held bit-stable.
- Flush:
  - redirect_valid=1 clears if_valid and the skid buffer on the next edge. Flush overrides stall.
  - A word accepted in the same cycle as a redirect is dropped, per the ack rule above.
- Simultaneous ack+redirect+stall: drop, load redirect_pc, flush; the stall has no effect.
- Reset mid-request: inst_req drops asynchronously; the bench must show no if_valid pulse after rst deasserts until a fresh ack arrives.
- All outputs are registered except inst_req/inst_addr, which are decoded from state/pc registers only (no input-to-output combinational path).

Decomposition:
- Shared package cpu_pkg:
  - constants RESET_PC_DEFAULT and PC_STEP_DEFAULT
  - fetch FSM state encoding, IDLE=1'b0 and REQ=1'b1
- One natural sub-module: fetch_skid_buf. It is a one-entry {pc, inst} buffer with push, pop, flush and full. It is instantiated once; all other logic stays in pc_fetch_ctrl.

Test Plan:
- Reset, then ack each request after 1 cycle: inst_addr sequence 0x0, 0x4, 0x8. if_valid pulses with if_pc 0x0/0x4/0x8 and if_inst equal to the fed words.
- Request at 0x8 outstanding, redirect_valid=1 with redirect_pc=0x100, ack 2 cycles later: the word is dropped, if_valid stays 0, and the next inst_addr is 0x100.
- Hold stall=1 with if_valid=1 (if_pc=0x4) and let the 0x8 fetch ack: 0x8 goes to the skid buffer, no further inst_req, and if_* stay stable. Release stall: 0x8 is presented the next cycle, then fetching resumes at 0xC.
- Ack, redirect to 0x40 and stall all in the same cycle: the word is dropped, if_valid=0, pc=0x40, and the skid buffer is empty.
- Set pc=0xFFFF_FFFC via redirect, then ack: if_pc=0xFFFF_FFFC and the next inst_addr is 0x0000_0000.
- Assert rst mid-REQ, asynchronously between edges: inst_req falls immediately, pc=RESET_PC, and if_valid=0. After release, the first fetch address is 0x0.
